// File: rtl/eth_phy_10g_pkg.sv
// Shared types and timing defaults for the 10G PHY RX reset sequencer.
package eth_phy_10g_pkg;

  // Default sequencing times in picoseconds, converted to 6.4 ns RX clock cycles
  localparam int unsigned RX_CLK_PERIOD_PS = 6400;
  localparam int unsigned RESET_PULSE_PS   = 102_400;
  localparam int unsigned DONE_TIMEOUT_PS  = 128_000_000;
  localparam int unsigned SETTLE_PS        = 1_638_400;
  localparam int unsigned HOLDOFF_PS       = 6_553_600;

  localparam int unsigned DEFAULT_RESET_PULSE_CYCLES = RESET_PULSE_PS / RX_CLK_PERIOD_PS;
  localparam int unsigned DEFAULT_DONE_TIMEOUT       = DONE_TIMEOUT_PS / RX_CLK_PERIOD_PS;
  localparam int unsigned DEFAULT_SETTLE_CYCLES      = SETTLE_PS / RX_CLK_PERIOD_PS;
  localparam int unsigned DEFAULT_HOLDOFF_CYCLES     = HOLDOFF_PS / RX_CLK_PERIOD_PS;
  localparam int unsigned DEFAULT_MAX_RETRIES        = 7;

  localparam int unsigned RETRY_W     = 4;
  localparam int unsigned RESET_CNT_W = 16;

  localparam logic [2:0] ST_ASSERT    = 3'd0;
  localparam logic [2:0] ST_WAIT_DONE = 3'd1;
  localparam logic [2:0] ST_SETTLE    = 3'd2;
  localparam logic [2:0] ST_HOLDOFF   = 3'd3;
  localparam logic [2:0] ST_IDLE      = 3'd4;
  localparam logic [2:0] ST_FAIL      = 3'd5;

  typedef enum logic [2:0] {
    S_ASSERT    = ST_ASSERT,
    S_WAIT_DONE = ST_WAIT_DONE,
    S_SETTLE    = ST_SETTLE,
    S_HOLDOFF   = ST_HOLDOFF,
    S_IDLE      = ST_IDLE,
    S_FAIL      = ST_FAIL
  } rx_rst_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/eth_phy_10g_rx_reset_ctrl_if.sv
// Request/status bundle between the RX reset sequencer and its watchdog, GT and management peers.
interface eth_phy_10g_rx_reset_ctrl_if;
  import eth_phy_10g_pkg::*;

  logic                   reset_req;
  logic                   force_reset;
  logic                   serdes_rx_reset_done;
  logic                   serdes_rx_reset;
  logic                   rx_datapath_rst;
  logic                   rx_reset_busy;
  logic                   rx_reset_fail;
  logic [RETRY_W-1:0]     retry_count;
  logic [RESET_CNT_W-1:0] reset_count;

  modport master (
    input  reset_req, force_reset, serdes_rx_reset_done,
    output serdes_rx_reset, rx_datapath_rst, rx_reset_busy, rx_reset_fail,
           retry_count, reset_count
  );

  modport slave (
    output reset_req, force_reset, serdes_rx_reset_done,
    input  serdes_rx_reset, rx_datapath_rst, rx_reset_busy, rx_reset_fail,
           retry_count, reset_count
  );
endinterface

// File: rtl/eth_phy_10g_rx_reset_ctrl.sv
// 10G SERDES RX reset sequencer: GT reset pulse, done wait with retry/timeout,
// settle and hold-off before the PCS datapath is released.
module eth_phy_10g_rx_reset_ctrl
  import eth_phy_10g_pkg::*;
#(
  parameter int unsigned RESET_PULSE_CYCLES = DEFAULT_RESET_PULSE_CYCLES,
  parameter int unsigned DONE_TIMEOUT       = DEFAULT_DONE_TIMEOUT,
  parameter int unsigned SETTLE_CYCLES      = DEFAULT_SETTLE_CYCLES,
  parameter int unsigned HOLDOFF_CYCLES     = DEFAULT_HOLDOFF_CYCLES,
  parameter int unsigned MAX_RETRIES        = DEFAULT_MAX_RETRIES
) (
  input  logic                          clk,
  input  logic                          rst,
  eth_phy_10g_rx_reset_ctrl_if.master   bus
);

  localparam int unsigned MAX_CYCLES = max_u(max_u(RESET_PULSE_CYCLES, DONE_TIMEOUT),
                                             max_u(SETTLE_CYCLES, HOLDOFF_CYCLES));
  localparam int unsigned CNT_W = $clog2(MAX_CYCLES) + 1;

  localparam logic [CNT_W-1:0] PULSE_LOAD   = CNT_W'(RESET_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(DONE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLDOFF_LOAD = CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRIES);

  rx_rst_state_e          state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [RETRY_W-1:0]     retry_q, retry_d;
  logic [RESET_CNT_W-1:0] reset_cnt_q;
  logic                   pwrup_q;
  logic                   entry_c;
  logic                   ser_rst_q, ser_rst_d;
  logic                   dp_rst_q, dp_rst_d;
  logic                   busy_q, busy_d;
  logic                   fail_q, fail_d;

  // State register, shared down-counter and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_ASSERT;
      cnt_q       <= PULSE_LOAD;
      retry_q     <= '0;
      reset_cnt_q <= '0;
      pwrup_q     <= 1'b1;
      ser_rst_q   <= 1'b1;
      dp_rst_q    <= 1'b1;
      busy_q      <= 1'b1;
      fail_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      pwrup_q   <= 1'b0;
      ser_rst_q <= ser_rst_d;
      dp_rst_q  <= dp_rst_d;
      busy_q    <= busy_d;
      fail_q    <= fail_d;
      // The ASSERT entered by reset release is counted on the first clock after it
      if ((pwrup_q || entry_c) && (reset_cnt_q != '1)) begin
        reset_cnt_q <= reset_cnt_q + RESET_CNT_W'(1);
      end
    end
  end

  // Next-state, counter reload and output decode of the next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    entry_c = 1'b0;

    if (bus.force_reset) begin
      state_d = S_ASSERT;
      cnt_d   = PULSE_LOAD;
      retry_d = '0;
      entry_c = 1'b1;
    end else begin
      unique case (state_q)
        S_ASSERT: begin
          if (cnt_q == '0) begin
            state_d = S_WAIT_DONE;
            cnt_d   = TIMEOUT_LOAD;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_WAIT_DONE: begin
          if (bus.serdes_rx_reset_done) begin
            state_d = S_SETTLE;
            cnt_d   = SETTLE_LOAD;
          end else if (cnt_q == '0) begin
            if (retry_q < RETRY_MAX) begin
              state_d = S_ASSERT;
              cnt_d   = PULSE_LOAD;
              retry_d = retry_q + RETRY_W'(1);
              entry_c = 1'b1;
            end else begin
              state_d = S_FAIL;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_SETTLE: begin
          // Losing done while settling restarts the pulse but is not a timeout
          if (!bus.serdes_rx_reset_done) begin
            state_d = S_ASSERT;
            cnt_d   = PULSE_LOAD;
            entry_c = 1'b1;
          end else if (cnt_q == '0) begin
            state_d = S_HOLDOFF;
            cnt_d   = HOLDOFF_LOAD;
            retry_d = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_HOLDOFF: begin
          if (cnt_q == '0) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_IDLE: begin
          if (bus.reset_req) begin
            state_d = S_ASSERT;
            cnt_d   = PULSE_LOAD;
            entry_c = 1'b1;
          end
        end
        S_FAIL: begin
          state_d = S_FAIL;
        end
        default: begin
          state_d = S_ASSERT;
          cnt_d   = PULSE_LOAD;
          entry_c = 1'b1;
        end
      endcase
    end

    ser_rst_d = (state_d == S_ASSERT);
    dp_rst_d  = !((state_d == S_HOLDOFF) || (state_d == S_IDLE));
    busy_d    = (state_d != S_IDLE);
    fail_d    = (state_d == S_FAIL);
  end

  assign bus.serdes_rx_reset = ser_rst_q;
  assign bus.rx_datapath_rst = dp_rst_q;
  assign bus.rx_reset_busy   = busy_q;
  assign bus.rx_reset_fail   = fail_q;
  assign bus.retry_count     = retry_q;
  assign bus.reset_count     = reset_cnt_q;

endmodule

// File: tb/tb_eth_phy_10g_rx_reset_ctrl.sv
// Scoreboard bench for the RX reset sequencer: expected output transitions are
// queued with their cycle numbers as stimulus is driven and matched as they occur.
module tb_eth_phy_10g_rx_reset_ctrl;

  typedef struct {
    int          sig;
    logic [15:0] val;
    int          cyc;
  } ev_t;

  typedef enum int {T_ASSERT, T_WAIT, T_SETTLE, T_HOLDOFF, T_IDLE, T_FAIL} tst_e;

  logic clk;
  logic rst;
  int   cyc;
  int   n_tests;
  int   n_fail;
  bit   mon_en;

  ev_t         sb_q[$];
  ev_t         ev;
  logic [15:0] lvl  [6];
  logic [15:0] prev [6];
  logic [15:0] cur  [6];

  eth_phy_10g_rx_reset_ctrl_if bus ();

  eth_phy_10g_rx_reset_ctrl #(
    .RESET_PULSE_CYCLES (16),
    .DONE_TIMEOUT       (50),
    .SETTLE_CYCLES      (256),
    .HOLDOFF_CYCLES     (1024),
    .MAX_RETRIES        (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic string sig_name(input int s);
    case (s)
      0:       return "serdes_rx_reset";
      1:       return "rx_datapath_rst";
      2:       return "rx_reset_busy";
      3:       return "rx_reset_fail";
      4:       return "retry_count";
      default: return "reset_count";
    endcase
  endfunction

  // Queue kept ordered by (cycle, signal) so it matches the monitor's scan order
  task automatic push_ev(input int s, input logic [15:0] v, input int c);
    ev_t e;
    int  i;
    e.sig = s;
    e.val = v;
    e.cyc = c;
    i = sb_q.size();
    while (i > 0 && (sb_q[i-1].cyc > c || (sb_q[i-1].cyc == c && sb_q[i-1].sig > s))) i--;
    sb_q.insert(i, e);
  endtask

  task automatic expect_sig(input int s, input logic [15:0] v, input int c);
    if (v != lvl[s]) begin
      push_ev(s, v, c);
      lvl[s] = v;
    end
  endtask

  task automatic enter(input tst_e st, input int c);
    expect_sig(0, 16'(st == T_ASSERT), c);
    expect_sig(1, 16'(!(st == T_HOLDOFF || st == T_IDLE)), c);
    expect_sig(2, 16'(st != T_IDLE), c);
    expect_sig(3, 16'(st == T_FAIL), c);
  endtask

  task automatic wait_cyc(input int n);
    int guard;
    guard = 0;
    while (cyc != n && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != n) check("wait_bound", 32'(cyc), 32'(n));
    #1;
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_serdes_rx_reset"}, 32'(bus.serdes_rx_reset), 32'd1);
    check({pfx, "_rx_datapath_rst"}, 32'(bus.rx_datapath_rst), 32'd1);
    check({pfx, "_rx_reset_busy"},   32'(bus.rx_reset_busy),   32'd1);
    check({pfx, "_rx_reset_fail"},   32'(bus.rx_reset_fail),   32'd0);
    check({pfx, "_retry_count"},     32'(bus.retry_count),     32'd0);
    check({pfx, "_reset_count"},     32'(bus.reset_count),     32'd0);
  endtask

  task automatic release_rst();
    lvl[0] = 16'd1; lvl[1] = 16'd1; lvl[2] = 16'd1;
    lvl[3] = 16'd0; lvl[4] = 16'd0; lvl[5] = 16'd0;
    rst    = 1'b0;
    mon_en = 1'b1;
  endtask

  // Transition monitor: every output change must match the head of the scoreboard
  always @(negedge clk) begin
    cur[0] = 16'(bus.serdes_rx_reset);
    cur[1] = 16'(bus.rx_datapath_rst);
    cur[2] = 16'(bus.rx_reset_busy);
    cur[3] = 16'(bus.rx_reset_fail);
    cur[4] = 16'(bus.retry_count);
    cur[5] = bus.reset_count;
    if (mon_en) begin
      for (int s = 0; s < 6; s++) begin
        if (cur[s] != prev[s]) begin
          if (sb_q.size() == 0) begin
            check({sig_name(s), "_unexpected"}, 32'(cur[s]), 32'(prev[s]));
          end else begin
            ev = sb_q.pop_front();
            check({sig_name(s), "_which"}, 32'(s),      32'(ev.sig));
            check({sig_name(s), "_value"}, 32'(cur[s]), 32'(ev.val));
            check({sig_name(s), "_cycle"}, 32'(cyc),    32'(ev.cyc));
          end
        end
      end
    end
    for (int s = 0; s < 6; s++) prev[s] = cur[s];
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    mon_en  = 1'b0;
    rst     = 1'b0;
    bus.reset_req            = 1'b0;
    bus.force_reset          = 1'b0;
    bus.serdes_rx_reset_done = 1'b0;
    #1 rst = 1'b1;
    #1 check_reset_vals("por");

    // Power-up: done arrives 10 cycles after the pulse; requests in SETTLE/HOLDOFF dropped
    @(negedge clk); #1;
    release_rst();
    expect_sig(5, 16'd1, 1);
    enter(T_WAIT, 16);
    wait_cyc(26);  bus.serdes_rx_reset_done = 1'b1;
    enter(T_SETTLE, 27);
    enter(T_HOLDOFF, 283);
    enter(T_IDLE, 1307);
    wait_cyc(100); bus.reset_req = 1'b1;
    wait_cyc(101); bus.reset_req = 1'b0;
    wait_cyc(500); bus.reset_req = 1'b1;
    wait_cyc(501); bus.reset_req = 1'b0;
    wait_cyc(1320); bus.reset_req = 1'b1; bus.serdes_rx_reset_done = 1'b0;
    enter(T_ASSERT, 1321);
    expect_sig(5, 16'd2, 1321);
    wait_cyc(1321); bus.reset_req = 1'b0;
    check("req_latency", 32'(bus.serdes_rx_reset), 32'd1);

    // One timeout, then done drops 100 cycles into SETTLE: retry_count must hold at 1
    enter(T_WAIT, 1337);
    enter(T_ASSERT, 1387);
    expect_sig(4, 16'd1, 1387);
    expect_sig(5, 16'd3, 1387);
    enter(T_WAIT, 1403);
    wait_cyc(1410); bus.serdes_rx_reset_done = 1'b1;
    enter(T_SETTLE, 1411);
    wait_cyc(1510); bus.serdes_rx_reset_done = 1'b0;
    enter(T_ASSERT, 1511);
    expect_sig(5, 16'd4, 1511);
    wait_cyc(1511);
    check("settle_drop_retry", 32'(bus.retry_count), 32'd1);
    enter(T_WAIT, 1527);

    // Asynchronous reset in the middle of WAIT_DONE, away from any clock edge
    wait_cyc(1540);
    mon_en = 1'b0;
    check("sb_drain_pre_rst", 32'(sb_q.size()), 32'd0);
    #2 rst = 1'b1;
    #1 check_reset_vals("async_rst");
    repeat (3) @(negedge clk);
    #1;
    release_rst();

    // Done never arrives: four pulses, retries 1..3, then FAIL
    expect_sig(5, 16'd1, 1);
    enter(T_WAIT, 16);
    for (int k = 1; k <= 3; k++) begin
      enter(T_ASSERT, 66 * k);
      expect_sig(4, 16'(k), 66 * k);
      expect_sig(5, 16'(k + 1), 66 * k);
      enter(T_WAIT, 66 * k + 16);
    end
    enter(T_FAIL, 264);
    wait_cyc(265);
    check("fail_flag",   32'(bus.rx_reset_fail), 32'd1);
    check("fail_rcount", 32'(bus.reset_count),   32'd4);
    check("fail_retry",  32'(bus.retry_count),   32'd3);
    wait_cyc(280); bus.reset_req = 1'b1;
    wait_cyc(281); bus.reset_req = 1'b0;
    wait_cyc(300); bus.force_reset = 1'b1;
    enter(T_ASSERT, 301);
    expect_sig(4, 16'd0, 301);
    expect_sig(5, 16'd5, 301);
    wait_cyc(301); bus.force_reset = 1'b0;
    check("force_retry_clr", 32'(bus.retry_count),   32'd0);
    check("force_fail_clr",  32'(bus.rx_reset_fail), 32'd0);
    enter(T_WAIT, 317);
    wait_cyc(320); bus.serdes_rx_reset_done = 1'b1;
    enter(T_SETTLE, 321);
    enter(T_HOLDOFF, 577);
    enter(T_IDLE, 1601);

    // force_reset mid-ASSERT reloads the pulse; force beats done in WAIT_DONE
    wait_cyc(1610); bus.reset_req = 1'b1;
    enter(T_ASSERT, 1611);
    expect_sig(5, 16'd6, 1611);
    wait_cyc(1611); bus.reset_req = 1'b0;
    wait_cyc(1620); bus.force_reset = 1'b1;
    expect_sig(5, 16'd7, 1621);
    wait_cyc(1621); bus.force_reset = 1'b0;
    enter(T_WAIT, 1637);
    wait_cyc(1637); bus.force_reset = 1'b1;
    enter(T_ASSERT, 1638);
    expect_sig(5, 16'd8, 1638);
    wait_cyc(1638); bus.force_reset = 1'b0;
    enter(T_WAIT, 1654);
    enter(T_SETTLE, 1655);
    enter(T_HOLDOFF, 1911);
    enter(T_IDLE, 2935);

    wait_cyc(2950);
    check("sb_drain_end",  32'(sb_q.size()),      32'd0);
    check("final_rcount",  32'(bus.reset_count),  32'd8);
    check("final_busy",    32'(bus.rx_reset_busy), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
